// File: rtl/tx_pkt_scheduler.sv
// tx_pkt_scheduler: packet-level BPSK/QPSK sequencer for the PSK transmit path.
// Starts each packet, tracks payload beats, waits for pkt_sent and enforces the inter-packet gap.
module tx_pkt_scheduler #(
  parameter int CNT_W   = 16,
  parameter int GAP_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_enable,
  input  logic             cfg_en,
  input  logic [7:0]       cfg_mode_pattern,
  input  logic [2:0]       cfg_pattern_len,
  input  logic [CNT_W-1:0] cfg_num_pkts,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic [15:0]      payload_length,
  input  logic             mon_tvalid,
  input  logic             mon_tready,
  input  logic             mon_tlast,
  input  logic             pkt_sent,
  output logic             pkt_start,
  output logic             pkt_is_bpsk,
  output logic [15:0]      payload_length_symbs,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pkt_count,
  output logic             timeout_err,
  output logic             len_err
);

  localparam int TMO_W = $clog2(TIMEOUT) + 32'sd1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0] GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 32'sd1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_GAP    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           state_r;
  logic [7:0]       pattern_r;
  logic [2:0]       pat_len_r;
  logic [CNT_W-1:0] num_pkts_r;
  logic [GAP_W-1:0] gap_r;
  logic [15:0]      payload_len_r;
  logic [2:0]       idx_r;
  logic [15:0]      beat_cnt_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic             en_drop_r;

  logic             pkt_start_r;
  logic             pkt_is_bpsk_r;
  logic [15:0]      symbs_r;
  logic             busy_r;
  logic             done_r;
  logic [CNT_W-1:0] pkt_count_r;
  logic             timeout_err_r;
  logic             len_err_r;

  logic             beat_s;
  logic             len_bad_s;
  logic [2:0]       idx_adv_s;
  logic [CNT_W-1:0] count_inc_s;
  logic             post_bpsk_s;
  logic             tmo_hit_s;
  logic             gap_end_s;
  logic             post_go_s;
  state_t           post_state_s;
  logic             post_busy_s;

  function automatic logic [15:0] symbs_of(input logic [15:0] len_bits, input logic bpsk);
    symbs_of = bpsk ? len_bits : (len_bits >> 1);
  endfunction

  // Beat detection, length check and the shared end-of-packet decision.
  always_comb begin
    beat_s      = mon_tvalid & mon_tready;
    len_bad_s   = (({1'b0, beat_cnt_r} + 17'd1) != {1'b0, symbs_r});
    idx_adv_s   = (idx_r == pat_len_r) ? 3'd0 : (idx_r + 3'd1);
    count_inc_s = pkt_count_r + CNT_ONE;
    post_bpsk_s = pattern_r[idx_adv_s];
    tmo_hit_s   = (tmo_cnt_r == TMO_LAST);
    gap_end_s   = (gap_cnt_r == (gap_r - GAP_ONE));
    case (state_r)
      S_STREAM: post_go_s = beat_s & mon_tlast & pkt_sent;
      S_DRAIN:  post_go_s = pkt_sent | tmo_hit_s;
      default:  post_go_s = 1'b0;
    endcase
    if ((num_pkts_r != CNT_ZERO) && (count_inc_s == num_pkts_r)) begin
      post_state_s = S_DONE;
    end else if (!cfg_en) begin
      post_state_s = S_IDLE;
    end else if (gap_r != GAP_ZERO) begin
      post_state_s = S_GAP;
    end else begin
      post_state_s = S_START;
    end
    post_busy_s = (post_state_s == S_GAP) || (post_state_s == S_START);
  end

  // Sequencer FSM; pkt_start and the packet attributes are set on entry to START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      pattern_r     <= 8'd0;
      pat_len_r     <= 3'd0;
      num_pkts_r    <= CNT_ZERO;
      gap_r         <= GAP_ZERO;
      payload_len_r <= 16'd0;
      idx_r         <= 3'd0;
      beat_cnt_r    <= 16'd0;
      tmo_cnt_r     <= TMO_ZERO;
      gap_cnt_r     <= GAP_ZERO;
      en_drop_r     <= 1'b0;
      pkt_start_r   <= 1'b0;
      pkt_is_bpsk_r <= 1'b0;
      symbs_r       <= 16'd0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      pkt_count_r   <= CNT_ZERO;
      timeout_err_r <= 1'b0;
      len_err_r     <= 1'b0;
    end else if (clk_enable) begin
      pkt_start_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (cfg_en) begin
            pattern_r     <= cfg_mode_pattern;
            pat_len_r     <= cfg_pattern_len;
            num_pkts_r    <= cfg_num_pkts;
            gap_r         <= cfg_gap;
            payload_len_r <= payload_length;
            pkt_count_r   <= CNT_ZERO;
            idx_r         <= 3'd0;
            timeout_err_r <= 1'b0;
            len_err_r     <= 1'b0;
            pkt_start_r   <= 1'b1;
            pkt_is_bpsk_r <= cfg_mode_pattern[0];
            symbs_r       <= symbs_of(payload_length, cfg_mode_pattern[0]);
            busy_r        <= 1'b1;
            done_r        <= 1'b0;
            state_r       <= S_START;
          end
        end
        S_START: begin
          beat_cnt_r <= 16'd0;
          state_r    <= S_STREAM;
        end
        S_STREAM: begin
          if (beat_s) begin
            beat_cnt_r <= beat_cnt_r + 16'd1;
            if (mon_tlast) begin
              if (len_bad_s) begin
                len_err_r <= 1'b1;
              end
              tmo_cnt_r <= TMO_ZERO;
              state_r   <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (tmo_hit_s & ~pkt_sent) begin
            timeout_err_r <= 1'b1;
          end
          tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
        end
        S_GAP: begin
          if (!cfg_en) begin
            en_drop_r <= 1'b1;
          end
          gap_cnt_r <= gap_cnt_r + GAP_ONE;
          if (gap_end_s) begin
            // A drop of cfg_en anywhere in the gap ends the run once the gap expires.
            if (en_drop_r | ~cfg_en) begin
              busy_r  <= 1'b0;
              state_r <= S_IDLE;
            end else begin
              pkt_start_r   <= 1'b1;
              pkt_is_bpsk_r <= pattern_r[idx_r];
              symbs_r       <= symbs_of(payload_len_r, pattern_r[idx_r]);
              state_r       <= S_START;
            end
          end
        end
        S_DONE: begin
          if (!cfg_en) begin
            done_r  <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
      // End of packet: overrides the DRAIN hand-off taken above when pkt_sent coincides with tlast.
      if (post_go_s) begin
        pkt_count_r <= count_inc_s;
        idx_r       <= idx_adv_s;
        gap_cnt_r   <= GAP_ZERO;
        en_drop_r   <= 1'b0;
        busy_r      <= post_busy_s;
        done_r      <= (post_state_s == S_DONE);
        state_r     <= post_state_s;
        if (post_state_s == S_START) begin
          pkt_start_r   <= 1'b1;
          pkt_is_bpsk_r <= post_bpsk_s;
          symbs_r       <= symbs_of(payload_len_r, post_bpsk_s);
        end
      end
    end
  end

  assign pkt_start            = pkt_start_r;
  assign pkt_is_bpsk          = pkt_is_bpsk_r;
  assign payload_length_symbs = symbs_r;
  assign busy                 = busy_r;
  assign done                 = done_r;
  assign pkt_count            = pkt_count_r;
  assign timeout_err          = timeout_err_r;
  assign len_err              = len_err_r;

endmodule
